// File: rtl/rng_share_ctrl_pkg.sv
// Shared types, constants and LFSR helpers for the shared random-number controller.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } rng_state_t;

  // Substituted for an all-ones seed, which is the lock-up state of an XNOR LFSR.
  localparam logic [63:0] DEFAULT_SEED = 64'h0123_4567_89AB_CDEF;

  // One shift of the 64-bit XNOR LFSR (taps 64,63,61,60).
  function automatic logic [63:0] lfsr64_step(input logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  // Replace the lock-up value so the register can never stall.
  function automatic logic [63:0] seed_guard(input logic [63:0] s);
    return (s == '1) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/rng_share_ctrl_arb.sv
// Combinational round-robin arbiter: picks the first set request bit
// searching upward from ptr+1, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_idx
);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // Rotating priority search; the last granted index has lowest priority.
  always_comb begin
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        win[w_idx]   = 1'b1;
        win_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/rng_share_ctrl.sv
// Owns a 64-bit XNOR LFSR and shares it between NREQ requesters.
// Sequence: seed load -> WARMUP discarded steps -> free-running RUN where
// round-robin grants hand out OUT_W-bit words at least OUT_W cycles apart,
// so no LFSR bit is handed out twice.
//
// Handshake: a requester raises req[i] and holds it until it observes
// gnt[i]; gnt is a one-cycle pulse with rnd_valid, rnd_data and rnd_id
// valid in the same cycle. req[i] still high in the following cycle is a
// new request. Dropping req before the grant is allowed.
module rng_share_ctrl
  import rng_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int OUT_W  = 16,
  parameter int WARMUP = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             seed_in,
  input  logic                    seed_load,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic                    rnd_valid,
  output logic [OUT_W-1:0]        rnd_data,
  output logic [$clog2(NREQ)-1:0] rnd_id,
  output logic                    rng_ready
);

  localparam int IDW   = $clog2(NREQ);
  localparam int GAP_W = 6;

  rng_state_t       r_state;
  rng_state_t       w_state_nxt;
  logic [63:0]      r_lfsr;
  logic [7:0]       r_warm_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic             r_ready;

  logic [NREQ-1:0]  w_win;
  logic [IDW-1:0]   w_win_idx;
  logic             w_grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req),
    .ptr     (r_rr_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a seed load wins over everything; WARM ends on its last step.
  always_comb begin
    w_state_nxt = r_state;
    if (seed_load) begin
      w_state_nxt = (WARMUP > 0) ? WARM : RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        WARM:    if (r_warm_cnt <= 8'd1) w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Grant decision: RUN only, spacing elapsed, someone asking, no reseed this edge.
  always_comb begin
    w_grant = (r_state == RUN) && !seed_load && (r_gap_cnt == '0) && (|req);
  end

  // LFSR, counters, round-robin pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr     <= '0;
      r_warm_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_gnt      <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_id       <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == RUN);
      r_gnt   <= w_grant ? w_win : '0;
      r_valid <= w_grant;
      if (seed_load) begin
        r_lfsr     <= seed_guard(seed_in);
        r_warm_cnt <= 8'(WARMUP);
        r_gap_cnt  <= '0;
      end else begin
        case (r_state)
          WARM: begin
            r_lfsr     <= lfsr64_step(r_lfsr);
            r_warm_cnt <= r_warm_cnt - 8'd1;
          end
          RUN: begin
            r_lfsr <= lfsr64_step(r_lfsr);
            if (w_grant) begin
              // Hand out the pre-step low bits; the gap guarantees fresh bits next time.
              r_data    <= r_lfsr[OUT_W-1:0];
              r_id      <= w_win_idx;
              r_rr_ptr  <= w_win_idx;
              r_gap_cnt <= GAP_W'(OUT_W - 1);
            end else if (r_gap_cnt != '0) begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign gnt       = r_gnt;
  assign rnd_valid = r_valid;
  assign rnd_data  = r_data;
  assign rnd_id    = r_id;
  assign rng_ready = r_ready;

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Bench for rng_share_ctrl: table of directed grant sequences, hand-written
// multi-cycle corner cases, and a randomized run against a reference model.
module tb_rng_share_ctrl;

  localparam int NREQ   = 4;
  localparam int OUT_W  = 16;
  localparam int WARMUP = 64;
  localparam int LIMIT  = NREQ * OUT_W;
  localparam logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] seed_in = '0;
  logic        seed_load = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic [1:0]  rnd_id;
  logic        rng_ready;

  rng_share_ctrl #(.NREQ(NREQ), .OUT_W(OUT_W), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .seed_in(seed_in), .seed_load(seed_load),
    .req(req), .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_id(rnd_id), .rng_ready(rng_ready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Once seeded, the LFSR simply advances every edge; RUN is "at least WARMUP
  // edges since the load"; a grant needs OUT_W edges since the previous one.
  int          n_tests = 0;
  int          n_fail  = 0;
  int          edge_cnt = 0;
  bit          m_loaded;
  int          m_n;
  int          m_last;
  int          m_ptr;
  logic [63:0] m_lfsr;
  logic [3:0]  e_gnt;
  logic        e_valid;
  logic [15:0] e_data;
  logic [1:0]  e_id;
  logic        e_ready;
  int          wait_cnt[NREQ];
  bit          ones_seen = 0;
  logic [17:0] exp_q[$];

  function automatic logic [63:0] ref_step(logic [63:0] s);
    return {s[62:0], ~(s[63] ^ s[62] ^ s[60] ^ s[59])};
  endfunction

  function automatic logic [63:0] ref_guard(logic [63:0] s);
    return (s == 64'hFFFF_FFFF_FFFF_FFFF) ? DEF_SEED : s;
  endfunction

  function automatic logic [63:0] ref_advance(logic [63:0] s, int n);
    logic [63:0] v = s;
    for (int i = 0; i < n; i++) v = ref_step(v);
    return v;
  endfunction

  function automatic int ref_pick(logic [3:0] r, int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic model_reset();
    m_loaded = 0; m_n = 0; m_last = -100000; m_ptr = NREQ - 1; m_lfsr = '0;
    e_gnt = '0; e_valid = 0; e_data = '0; e_id = '0; e_ready = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Raise reset right now (between edges): outputs must clear without an edge.
  task automatic async_reset_now();
    reset = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt), 64'd0);
    chk("async_valid", 64'(rnd_valid), 64'd0);
    chk("async_data", 64'(rnd_data), 64'd0);
    chk("async_id", 64'(rnd_id), 64'd0);
    chk("async_ready", 64'(rng_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    seed_load = 1'b0;
    async_reset_now();
  endtask

  // One clock edge: sample inputs, advance the model, compare all outputs.
  task automatic tick();
    logic [63:0] s_seed;
    logic        s_load;
    logic [3:0]  s_req;
    int          w;
    logic [17:0] sb;
    s_seed = seed_in; s_load = seed_load; s_req = req;
    @(posedge clk);
    #1;
    edge_cnt++;
    e_gnt = '0; e_valid = 0;
    if (s_load) begin
      m_lfsr = ref_guard(s_seed); m_loaded = 1; m_n = 0; m_last = -100000;
      e_ready = (WARMUP == 0);
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else if (m_loaded) begin
      if (m_n >= WARMUP) begin
        w = -1;
        if ((|s_req) && (m_n - m_last) >= OUT_W) w = ref_pick(s_req, m_ptr);
        for (int i = 0; i < NREQ; i++) begin
          if (s_req[i]) wait_cnt[i]++; else wait_cnt[i] = 0;
        end
        if (w >= 0) begin
          e_gnt[w] = 1'b1; e_valid = 1; e_data = m_lfsr[15:0]; e_id = 2'(w);
          chk("starve_wait", 64'(wait_cnt[w] <= LIMIT), 64'd1);
          wait_cnt[w] = 0; m_ptr = w; m_last = m_n;
          exp_q.push_back({e_id, e_data});
        end
      end
      m_lfsr = ref_step(m_lfsr); m_n++;
      e_ready = (m_n >= WARMUP);
    end
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("rnd_valid", 64'(rnd_valid), 64'(e_valid));
    chk("rnd_data", 64'(rnd_data), 64'(e_data));
    chk("rnd_id", 64'(rnd_id), 64'(e_id));
    chk("rng_ready", 64'(rng_ready), 64'(e_ready));
    chk("lfsr", dut.r_lfsr, m_lfsr);
    if (dut.r_lfsr == 64'hFFFF_FFFF_FFFF_FFFF) ones_seen = 1;
    // scoreboard: every valid word must match the oldest expected grant
    if (rnd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected @edge %0d: got word %0h expected none", edge_cnt, {rnd_id, rnd_data});
      end else begin
        sb = exp_q.pop_front();
        chk("sb_word", 64'({rnd_id, rnd_data}), 64'(sb));
      end
    end
  endtask

  task automatic load_seed(logic [63:0] s);
    seed_in = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (rng_ready !== 1'b1 && b < 200) begin tick(); b++; end
    chk("ready_timeout", 64'(rng_ready), 64'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [63:0] seed;
    logic [3:0]  req;
    logic [19:0] exp_seq;   // five expected gnt values, first in [3:0]
    logic [15:0] exp_data0; // data of the first grant
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [63:0] tmp;
    logic [3:0]  got[5];
    int          at[5];
    int          gi, b, load_edge, cnt;
    logic [15:0] data0;
    bit          flag;

    model_reset();

    vecs[0] = '{seed: 64'h1, req: 4'b1111, exp_seq: {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001}, exp_data0: '0};
    vecs[1] = '{seed: 64'hFFFF_FFFF_FFFF_FFFF, req: 4'b1010, exp_seq: {4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010}, exp_data0: '0};
    vecs[2] = '{seed: {$urandom, $urandom}, req: 4'b0100, exp_seq: {5{4'b0100}}, exp_data0: '0};
    vecs[3] = '{seed: 64'h5A5A_C3C3_0F0F_9696, req: 4'b1001, exp_seq: {4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001}, exp_data0: '0};
    for (int v = 0; v < 4; v++) begin
      tmp = ref_advance(ref_guard(vecs[v].seed), WARMUP);
      vecs[v].exp_data0 = tmp[15:0];
    end

    // reset state
    do_reset();
    chk("reset_lfsr", dut.r_lfsr, 64'd0);

    // IDLE ignores requests
    req = 4'b0001;
    flag = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (gnt != 0 || rnd_valid) flag = 1; end
    chk("idle_no_grant", 64'(flag), 64'd0);
    req = '0;

    // warm-up timing: ready first high after the 64th post-load edge
    // (65 edges counting the load edge); LFSR = seed advanced 64 times
    do_reset();
    load_seed(64'h1);
    cnt = 0;
    while (rng_ready !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    chk("warm_ready_edges", 64'(cnt), 64'(WARMUP));
    chk("warm_lfsr64", dut.r_lfsr, ref_advance(64'h1, WARMUP));

    // all-ones seed is replaced by the default seed
    do_reset();
    load_seed(64'hFFFF_FFFF_FFFF_FFFF);
    chk("guard_seed", dut.r_lfsr, DEF_SEED);
    for (int i = 0; i < 300; i++) tick();

    // table-driven grant sequences
    for (int v = 0; v < 4; v++) begin
      do_reset();
      load_seed(vecs[v].seed);
      load_edge = edge_cnt;
      req = vecs[v].req;
      gi = 0; b = 0; data0 = '0;
      while (gi < 5 && b < 400) begin
        tick(); b++;
        if (gnt != 0) begin
          if (gi == 0) data0 = rnd_data;
          got[gi] = gnt; at[gi] = edge_cnt; gi++;
        end
      end
      chk("vec_grant_count", 64'(gi), 64'd5);
      for (int k = 0; k < gi; k++) begin
        chk("vec_gnt", 64'(got[k]), 64'(vecs[v].exp_seq[k*4 +: 4]));
        if (k == 0) chk("vec_first_edge", 64'(at[0] - load_edge), 64'(WARMUP + 1));
        else        chk("vec_spacing", 64'(at[k] - at[k-1]), 64'(OUT_W));
      end
      chk("vec_data0", 64'(data0), 64'(vecs[v].exp_data0));
      req = '0;
    end

    // reseed mid-RUN with a pending request
    do_reset();
    load_seed(64'hDEAD_BEEF_0000_1234);
    wait_ready();
    for (int i = 0; i < 20; i++) tick();
    req = 4'b0100; seed_in = 64'h0BAD_F00D_1357_9BDF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("reseed_ready_low", 64'(rng_ready), 64'd0);
    chk("reseed_no_gnt", 64'(gnt), 64'd0);
    flag = 0;
    for (int i = 0; i < WARMUP; i++) begin tick(); if (gnt != 0) flag = 1; end
    chk("reseed_warm_no_gnt", 64'(flag), 64'd0);
    tick();
    chk("reseed_first_run_gnt", 64'(gnt), 64'b0100);
    req = '0;

    // async reset between edges while warming up, after earlier grants
    do_reset();
    load_seed(64'h7777_1111_2222_3333);
    wait_ready();
    req = 4'b0011;
    for (int i = 0; i < 40; i++) tick();
    req = '0;
    load_seed(64'h4444_5555_6666_7777);
    for (int i = 0; i < 10; i++) tick();
    #3;
    async_reset_now();
    req = 4'b1111;
    flag = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (gnt != 0) flag = 1; end
    chk("post_reset_no_gnt", 64'(flag), 64'd0);
    load_seed(64'h9);
    b = 0;
    while (gnt == 0 && b < 200) begin tick(); b++; end
    chk("post_reset_first_gnt", 64'(gnt), 64'b0001);
    req = '0;

    // request raised and dropped inside the spacing window is never granted
    do_reset();
    load_seed(64'h2468);
    wait_ready();
    req = 4'b0001;
    b = 0;
    while (gnt == 0 && b < 100) begin tick(); b++; end
    chk("gap_setup_gnt", 64'(gnt), 64'b0001);
    req = '0;
    tick(); tick();
    req = 4'b0010;
    tick(); tick(); tick();
    req = '0;
    flag = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (gnt != 0) flag = 1; end
    chk("gap_drop_no_gnt", 64'(flag), 64'd0);

    // randomized traffic with occasional reseeds and resets
    begin
      bit need_load;
      do_reset();
      need_load = 1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 1499) == 0) begin do_reset(); need_load = 1; end
        seed_load = need_load || ($urandom_range(0, 499) == 0);
        if (seed_load) begin
          seed_in = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
          need_load = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (req[i]) begin
            if (gnt[i] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0)) req[i] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
          end
        end
        tick();
        seed_load = 1'b0;
      end
      req = '0;
      for (int i = 0; i < 5; i++) tick();
    end

    chk("lfsr_never_all_ones", 64'(ones_seen), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
